// File: rtl/mem_wb_queue.sv
// mem_wb_queue: elastic in-order MEM/WB queue.
// Decouples variable-latency memory from a stalled write-back.
module mem_wb_queue #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int DEPTH  = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_en_in,
  input  logic              MEM_R_en_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] Mem_read_value_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_en,
  output logic              MEM_R_en,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] MEM_result,
  output logic [DEST_W-1:0] Dest,
  output logic [CW-1:0]     count
);

  typedef struct packed {
    logic              wb;
    logic              mr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [DEST_W-1:0] dest;
  } ent_t;

  ent_t          stor [DEPTH];
  ent_t          din;
  ent_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // handshake derived from registered state and freeze/flush only
  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    in_ready  = !full && !freeze && !flush;
    out_valid = !empty && !freeze && !flush;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    din.wb    = WB_en_in;
    din.mr    = MEM_R_en_in;
    din.alu   = ALU_result_in;
    din.mem   = Mem_read_value_in;
    din.dest  = Dest_in;
  end

  // head presentation; control bits gated so no stray write-back
  always_comb begin
    head       = stor[rd_ptr];
    WB_en      = head.wb && out_valid;
    MEM_R_en   = head.mr && out_valid;
    address    = head.alu;
    MEM_result = head.mem;
    Dest       = head.dest;
  end

  // entry storage; contents left stale on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stor[i] <= '0;
    end else if (push) begin
      stor[wr_ptr] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_queue.sv
// tb_mem_wb_queue: directed scoreboard bench for mem_wb_queue.
// A model queue predicts handshakes, occupancy and head data.
module tb_mem_wb_queue;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int DP = 4;
  localparam int EW = 2 + 2 * DW + RW;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze, flush;
  logic          in_valid, in_ready;
  logic          WB_en_in, MEM_R_en_in;
  logic [DW-1:0] ALU_result_in, Mem_read_value_in;
  logic [RW-1:0] Dest_in;
  logic          out_valid, out_ready;
  logic          WB_en, MEM_R_en;
  logic [DW-1:0] address, MEM_result;
  logic [RW-1:0] Dest;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] sb [$];

  mem_wb_queue #(.DATA_W(DW), .DEST_W(RW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB_en_in(WB_en_in), .MEM_R_en_in(MEM_R_en_in),
    .ALU_result_in(ALU_result_in),
    .Mem_read_value_in(Mem_read_value_in),
    .Dest_in(Dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_en(WB_en), .MEM_R_en(MEM_R_en),
    .address(address), .MEM_result(MEM_result),
    .Dest(Dest), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [EW-1:0] obs,
                     input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic wb,
                        input logic mr, input logic [DW-1:0] alu,
                        input logic [DW-1:0] mv,
                        input logic [RW-1:0] d);
    in_valid          = v;
    WB_en_in          = wb;
    MEM_R_en_in       = mr;
    ALU_result_in     = alu;
    Mem_read_value_in = mv;
    Dest_in           = d;
  endtask

  task automatic set_k(input int k);
    logic [31:0] kv;
    kv = k;
    set_in(1'b1, kv[0], kv[1], kv, ~kv, kv[3:0]);
  endtask

  // check at negedge, update model, advance to posedge+1
  task automatic cycle(input string tag, output bit acc);
    bit eir, eov;
    logic [EW-1:0] cur;
    @(negedge clk);
    eir = (sb.size() < DP) && !freeze && !flush;
    eov = (sb.size() > 0) && !freeze && !flush;
    chk({tag, "_in_ready"}, EW'(in_ready), EW'(eir));
    chk({tag, "_out_valid"}, EW'(out_valid), EW'(eov));
    chk({tag, "_count"}, EW'(count), EW'(sb.size()));
    if (eov)
      chk({tag, "_head"},
          {WB_en, MEM_R_en, address, MEM_result, Dest}, sb[0]);
    else
      chk({tag, "_gate"}, EW'({WB_en, MEM_R_en}), EW'(0));
    cur = {WB_en_in, MEM_R_en_in, ALU_result_in,
           Mem_read_value_in, Dest_in};
    acc = eir && in_valid;
    if (flush) sb.delete();
    else begin
      if (eov && out_ready) void'(sb.pop_front());
      if (acc) sb.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12 && sb.size() > 0; i++) cycle(tag, a);
    cycle({tag, "_idle"}, a);
  endtask

  initial begin
    bit a;
    rst = 1'b0;
    freeze = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #12;
    chk("rst_count", EW'(count), EW'(0));
    chk("rst_out_valid", EW'(out_valid), EW'(0));
    chk("rst_ctrl", EW'({WB_en, MEM_R_en}), EW'(0));
    chk("rst_data", EW'({address, MEM_result, Dest}), EW'(0));
    rst = 1'b1;
    #1;
    chk("rst_in_ready", EW'(in_ready), EW'(1));
    @(posedge clk);
    #1;

    // single transfer
    out_ready = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'd5);
    cycle("single_push", a);
    in_valid = 1'b0;
    cycle("single_out", a);
    cycle("single_after", a);

    // backpressure and wrap
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_k(k);
      cycle("bp_fill", a);
    end
    set_k(5);
    cycle("bp_hold", a);
    chk("bp_5_held", EW'(a), EW'(0));
    out_ready = 1'b1;
    a = 1'b0;
    for (int i = 0; i < 8 && !a; i++) cycle("bp_wait5", a);
    chk("bp_5_taken", EW'(a), EW'(1));
    drain("bp_drain");

    // simultaneous push/pop, then full with pop
    out_ready = 1'b0;
    for (int k = 16; k < 18; k++) begin
      set_k(k);
      cycle("pp_fill", a);
    end
    out_ready = 1'b1;
    set_k(18);
    cycle("pp_both", a);
    out_ready = 1'b0;
    for (int k = 19; k < 21; k++) begin
      set_k(k);
      cycle("pp_full", a);
    end
    out_ready = 1'b1;
    set_k(21);
    cycle("full_pop", a);
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycle("full_after", a);

    // flush with count = 3 and in_valid high
    set_k(22);
    flush = 1'b1;
    out_ready = 1'b1;
    cycle("flush", a);
    flush = 1'b0;
    in_valid = 1'b0;
    cycle("flush_after", a);
    set_k(23);
    cycle("flush_new", a);
    drain("flush_drain");

    // freeze for 3 cycles at count = 2
    out_ready = 1'b0;
    for (int k = 32; k < 34; k++) begin
      set_k(k);
      cycle("frz_fill", a);
    end
    freeze = 1'b1;
    out_ready = 1'b1;
    set_k(34);
    for (int i = 0; i < 3; i++) cycle("frz", a);
    freeze = 1'b0;
    drain("frz_drain");

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int k = 40; k < 42; k++) begin
      set_k(k);
      cycle("ar_fill", a);
    end
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("ar_count", EW'(count), EW'(0));
    chk("ar_out_valid", EW'(out_valid), EW'(0));
    chk("ar_wb", EW'(WB_en), EW'(0));
    chk("ar_dest", EW'(Dest), EW'(0));
    sb.delete();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_in_ready", EW'(in_ready), EW'(1));
    @(posedge clk);
    #1;
    set_k(50);
    out_ready = 1'b1;
    cycle("ar_push", a);
    drain("ar_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
